// File: rtl/yuv2rgb_stream_converter.sv
// Three-stage YUV-to-RGB converter: offset subtract, coefficient multiply, sum/shift/clamp.
// Bypass beats carry raw Y/U/V alongside the arithmetic and are selected in the last stage.
module yuv2rgb_stream_converter #(
  parameter int LANES        = 2,
  parameter int DW           = 8,
  parameter int COEF_W       = 20,
  parameter int FRAC         = 16,
  parameter int C_Y          = 76284,
  parameter int C_RV         = 104595,
  parameter int C_GU         = -25624,
  parameter int C_GV         = -53281,
  parameter int C_BU         = 132251,
  parameter int Y_OFF        = 16,
  parameter int C_OFF        = 128,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    bypass,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DW-1:0]     in_y,
  input  logic [DW-1:0]           in_u,
  input  logic [DW-1:0]           in_v,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*3*DW-1:0]   out_data,
  output logic                    out_last,
  output logic [19:0]             pix_count
);

  localparam int OW = DW + 1;
  localparam int PW = COEF_W + DW + 1;
  localparam int SW = PW + 2;

  localparam logic signed [PW-1:0] K_Y  = PW'(COEF_W'(C_Y));
  localparam logic signed [PW-1:0] K_RV = PW'(COEF_W'(C_RV));
  localparam logic signed [PW-1:0] K_GU = PW'(COEF_W'(C_GU));
  localparam logic signed [PW-1:0] K_GV = PW'(COEF_W'(C_GV));
  localparam logic signed [PW-1:0] K_BU = PW'(COEF_W'(C_BU));
  localparam logic signed [OW-1:0] Y_OFF_S = OW'(Y_OFF);
  localparam logic signed [OW-1:0] C_OFF_S = OW'(C_OFF);

  logic                   adv;
  logic                   out_hs;
  logic [19:0]            pix_next;
  logic [LANES*3*DW-1:0]  s3_data;
  logic                   s3_last;

  logic                   s1_valid, s1_byp;
  logic signed [OW-1:0]   s1_y [LANES];
  logic signed [OW-1:0]   s1_u, s1_v;
  logic [LANES*DW-1:0]    s1_raw_y;
  logic [DW-1:0]          s1_raw_u, s1_raw_v;

  logic                   s2_valid, s2_byp;
  logic signed [PW-1:0]   s2_py [LANES];
  logic signed [PW-1:0]   s2_prv, s2_pgu, s2_pgv, s2_pbu;
  logic [LANES*DW-1:0]    s2_raw_y;
  logic [DW-1:0]          s2_raw_u, s2_raw_v;

  function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] q;
    q = s >>> FRAC;
    if (q[SW-1])
      sat = '0;
    else if (|q[SW-2:DW])
      sat = '1;
    else
      sat = q[DW-1:0];
  endfunction

  function automatic logic [3*DW-1:0] matrix(input logic signed [PW-1:0] py, prv, pgu, pgv, pbu);
    logic signed [SW-1:0] r, g, b;
    r = SW'(py) + SW'(prv);
    g = SW'(py) + SW'(pgu) + SW'(pgv);
    b = SW'(py) + SW'(pbu);
    return {sat(r), sat(g), sat(b)};
  endfunction

  always_comb begin
    adv      = out_ready | ~out_valid;
    in_ready = adv;
    out_hs   = out_valid & out_ready;
    pix_next = pix_count;
    if (out_hs)
      pix_next = (pix_count + 20'(LANES) == 20'(FRAME_PIXELS)) ? '0 : pix_count + 20'(LANES);
    // The beat loaded into S3 is presented when the count equals pix_next.
    s3_last = (pix_next + 20'(LANES) == 20'(FRAME_PIXELS));
    s3_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (s2_byp)
        s3_data[i*3*DW +: 3*DW] = {s2_raw_y[i*DW +: DW], s2_raw_u, s2_raw_v};
      else
        s3_data[i*3*DW +: 3*DW] = matrix(s2_py[i], s2_prv, s2_pgu, s2_pgv, s2_pbu);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_byp    <= 1'b0;
      s1_u      <= '0;
      s1_v      <= '0;
      s1_raw_y  <= '0;
      s1_raw_u  <= '0;
      s1_raw_v  <= '0;
      s2_valid  <= 1'b0;
      s2_byp    <= 1'b0;
      s2_prv    <= '0;
      s2_pgu    <= '0;
      s2_pgv    <= '0;
      s2_pbu    <= '0;
      s2_raw_y  <= '0;
      s2_raw_u  <= '0;
      s2_raw_v  <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        s1_y[i]  <= '0;
        s2_py[i] <= '0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      pix_count <= '0;
    end else if (clr) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      pix_count <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_byp   <= bypass;
      s1_raw_y <= in_y;
      s1_raw_u <= in_u;
      s1_raw_v <= in_v;
      s1_u     <= $signed({1'b0, in_u}) - C_OFF_S;
      s1_v     <= $signed({1'b0, in_v}) - C_OFF_S;
      for (int unsigned i = 0; i < LANES; i++) begin
        s1_y[i]  <= $signed({1'b0, in_y[i*DW +: DW]}) - Y_OFF_S;
        s2_py[i] <= PW'(s1_y[i]) * K_Y;
      end
      s2_valid  <= s1_valid;
      s2_byp    <= s1_byp;
      s2_raw_y  <= s1_raw_y;
      s2_raw_u  <= s1_raw_u;
      s2_raw_v  <= s1_raw_v;
      s2_prv    <= PW'(s1_v) * K_RV;
      s2_pgu    <= PW'(s1_u) * K_GU;
      s2_pgv    <= PW'(s1_v) * K_GV;
      s2_pbu    <= PW'(s1_u) * K_BU;
      out_valid <= s2_valid;
      out_data  <= s3_data;
      out_last  <= s3_last;
      pix_count <= pix_next;
    end
  end

endmodule

// File: tb/tb_yuv2rgb_stream_converter.sv
// Bench for yuv2rgb_stream_converter: directed beats plus a randomized stream scored
// against an integer colour-conversion model and an ideal frame pixel counter.
module tb_yuv2rgb_stream_converter;

  localparam int LANES = 2;
  localparam int DW    = 8;
  localparam int FRAME = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        bypass = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_y = '0;
  logic [7:0]  in_u = '0;
  logic [7:0]  in_v = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] out_data;
  logic        out_last;
  logic [19:0] pix_count;

  yuv2rgb_stream_converter #(
    .LANES(LANES),
    .DW(DW),
    .FRAME_PIXELS(FRAME)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .bypass(bypass),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_y(in_y),
    .in_u(in_u),
    .in_v(in_v),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          cnt = 0;
  int          lat_mark = -1;
  bit          lat_arm = 0;
  bit          got_acc = 0;
  bit          was_stall = 0;
  logic [47:0] stall_data = '0;
  bit          pend_use = 0;
  logic [47:0] pend_exp = '0;
  logic [47:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    else
      n_pass++;
  endtask

  function automatic logic [7:0] clampf(input int x);
    if (x < 0) return 8'd0;
    if (x > 255) return 8'd255;
    return 8'(x);
  endfunction

  function automatic logic [47:0] ref_beat(input logic [15:0] ys, input logic [7:0] u,
                                           input logic [7:0] v, input logic byp);
    logic [47:0] r;
    int yy, uu, vv;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (byp) begin
        r[i*24 +: 24] = {ys[i*8 +: 8], u, v};
      end else begin
        yy = int'(ys[i*8 +: 8]) - 16;
        uu = int'(u) - 128;
        vv = int'(v) - 128;
        r[i*24 +: 24] = {clampf((76284*yy + 104595*vv) >>> 16),
                         clampf((76284*yy - 25624*uu - 53281*vv) >>> 16),
                         clampf((76284*yy + 132251*uu) >>> 16)};
      end
    end
    return r;
  endfunction

  task automatic step();
    bit acc, oh;
    logic [47:0] e;
    @(negedge clk);
    cyc++;
    acc = in_valid && in_ready;
    oh  = out_valid && out_ready;
    got_acc = acc && !clr;
    check("pix_count", 64'(pix_count), 64'(cnt));
    if (was_stall) begin
      check("stall_hold_data", 64'(out_data), 64'(stall_data));
      check("stall_hold_valid", 64'(out_valid), 64'(1));
    end
    if (out_valid && !out_ready)
      check("stall_in_ready", 64'(in_ready), 64'(0));
    was_stall  = out_valid && !out_ready && !clr;
    stall_data = out_data;
    if (lat_mark >= 0 && out_valid) begin
      check("latency", 64'(cyc - lat_mark), 64'(3));
      lat_mark = -1;
    end
    if (clr) begin
      exp_q.delete();
      cnt = 0;
    end else begin
      if (oh) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(e));
          check("out_last", 64'(out_last), 64'(cnt + LANES == FRAME));
          cnt = (cnt + LANES == FRAME) ? 0 : cnt + LANES;
        end
      end
      if (acc) begin
        exp_q.push_back(pend_use ? pend_exp : ref_beat(in_y, in_u, in_v, bypass));
        if (lat_arm) begin
          lat_mark = cyc;
          lat_arm  = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] y, input logic [7:0] u, input logic [7:0] v,
                       input logic byp, input bit use_exp, input logic [47:0] exp);
    in_valid = 1'b1;
    in_y     = y;
    in_u     = u;
    in_v     = v;
    bypass   = byp;
    pend_use = use_exp;
    pend_exp = exp;
  endtask

  task automatic put(input logic [15:0] y, input logic [7:0] u, input logic [7:0] v,
                     input logic byp, input bit use_exp, input logic [47:0] exp);
    bit ok;
    ok = 0;
    drive(y, u, v, byp, use_exp, exp);
    for (int k = 0; k < 20 && !ok; k++) begin
      step();
      ok = got_acc;
    end
    if (!ok) check("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic put_rand();
    put(16'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, '0);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr       = 1'b0;
    for (int k = 0; k < 40 && (exp_q.size() != 0 || out_valid); k++)
      step();
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    if (lat_mark >= 0) begin
      check("latency_timeout", 64'(1), 64'(0));
      lat_mark = -1;
    end
  endtask

  initial begin
    // Reset values while rst is held low
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_pix_count", 64'(pix_count), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Black level, latency
    lat_arm = 1;
    put({8'd16, 8'd16}, 8'd128, 8'd128, 1'b0, 1'b1, 48'h000000_000000);
    drain();

    // White/over-range clamp, then negative clamp
    put({8'd255, 8'd235}, 8'd128, 8'd128, 1'b0, 1'b1, 48'hFFFFFF_FEFEFE);
    put({8'd0, 8'd0}, 8'd128, 8'd128, 1'b0, 1'b1, 48'h000000_000000);
    drain();

    // Floor shift of small negative G/B sums
    put({8'd81, 8'd81}, 8'd90, 8'd240, 1'b0, 1'b1, 48'hFE0000_FE0000);
    drain();

    // Bypass interleaved with normal beats
    put_rand();
    put({8'd20, 8'd10}, 8'd30, 8'd40, 1'b1, 1'b1, 48'h141E28_0A1E28);
    put_rand();
    drain();

    // Stall for 5 cycles mid-stream
    put_rand();
    put_rand();
    put_rand();
    out_ready = 1'b0;
    drive(16'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, '0);
    repeat (5) step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Continuous stream across several frames
    for (int k = 0; k < 16; k++) put_rand();
    drain();

    // clr with beats in flight and a coinciding input beat
    put_rand();
    drain();
    put_rand();
    put_rand();
    drive(16'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, '0);
    clr = 1'b1;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_out_valid", 64'(out_valid), 64'(0));
    check("clr_pix_count", 64'(pix_count), 64'(0));
    drain();

    // Randomized traffic with backpressure, bypass and occasional clr
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_y      = ($urandom_range(0, 7) == 0) ? 16'hFF00 : 16'($urandom);
      in_u      = 8'($urandom);
      in_v      = 8'($urandom);
      bypass    = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      clr       = ($urandom_range(0, 59) == 0);
      pend_use  = 0;
      step();
    end
    clr = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/yuv2rgb_stream_converter.md
Name: yuv2rgb_stream_converter

Overview:
Streaming, pipelined YUV-to-RGB colour converter. It is the parametrised successor of the fixed 2-pixel colour conversion datapath. It accepts LANES luma samples plus one shared U/V pair per beat (4:2:2 when LANES=2), applies a programmable fixed-point 3x3 matrix, clamps each result, and emits packed RGB with a valid/ready handshake. It sits between the SRAM read sequencer and the RGB write-back path and tracks frame position so it can flag end of frame.

Parameters:
LANES, 2, luma samples (output pixels) per beat; legal values 1..4
DW, 8, bits per input and output component
COEF_W, 20, signed coefficient width (two's complement)
FRAC, 16, fractional bits in the coefficients
C_Y, 76284, Y coefficient, shared by R, G and B
C_RV, 104595, V coefficient into R
C_GU, -25624, U coefficient into G
C_GV, -53281, V coefficient into G
C_BU, 132251, U coefficient into B
Y_OFF, 16, luma offset
C_OFF, 128, chroma offset
FRAME_PIXELS, 76800, output pixels per frame; must be a multiple of LANES

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-low reset
clr  in  1  synchronous clear: flushes the pipeline and zeroes the pixel counter
bypass  in  1  per-beat mode, sampled with the beat; 1 passes Y/U/V through as R/G/B
in_valid  in  1  input beat valid
in_ready  out  1  converter can accept a beat
in_y  in  LANES*DW  luma; lane i occupies [DW*i+DW-1 : DW*i]
in_u  in  DW  chroma U, shared by all lanes of the beat
in_v  in  DW  chroma V, shared by all lanes of the beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_data  out  LANES*3*DW  lane i occupies [3DW*i+3DW-1 : 3DW*i], packed {R,G,B} with R in the MSBs
out_last  out  1  qualifies out_data: this beat completes the frame
pix_count  out  20  output pixels accepted so far in the current frame

Behaviour:
- Reset (rst=0, asynchronous): all stage valid bits = 0; out_valid=0, out_data=0, out_last=0, pix_count=0.
- in_ready is high out of reset.
- Pipeline has 3 stages: S1 registers offset-subtracted operands, S2 registers the products, S3 registers sum/shift/clamp. Latency is 3 cycles from input accept to out_valid when there is no stall.
- Advance enable: adv = out_ready | ~out_valid. Every stage moves only when adv=1, and in_ready = adv.
- Input is accepted when in_valid & in_ready.
- Throughput is one beat per cycle. Bubbles propagate; they are not collapsed.
- While out_valid=1 and out_ready=0: out_data, out_last and all stages hold; in_ready=0.
- Arithmetic, per lane, in signed form:
  - y = Y-Y_OFF, u = U-C_OFF, v = V-C_OFF, each DW+1 bits.
  - Products are COEF_W+DW+1 bits; sums carry 2 extra guard bits.
  - R = (C_Y*y + C_RV*v) >>> FRAC
  - G = (C_Y*y + C_GU*u + C_GV*v) >>> FRAC
  - B = (C_Y*y + C_BU*u) >>> FRAC
  - >>> is an arithmetic (floor) shift with no rounding.
- Clamp: results below 0 become 0; results above 2^DW-1 become 2^DW-1.
- Bypass: R=Y(lane), G=U, B=V. No offset and no clamp. Bypass travels through the pipeline with its beat, so latency is the same.
- Frame tracking:
  - On each output handshake (out_valid & out_ready), pix_count += LANES.
  - out_last=1 on the beat where pix_count+LANES == FRAME_PIXELS. On that handshake pix_count wraps to 0.
  - out_last is registered alongside out_data and is valid only while out_valid=1.
- clr:
  - All stage valid bits and pix_count go to 0 on the next edge; in-flight beats are dropped.
  - clr has priority over a simultaneous input or output handshake. Neither handshake takes effect in that cycle: no beat is accepted and no count is added.
  - out_data is not required to be cleared.
- Reset asserted mid-frame: identical to clr, but asynchronous.

Test Plan:
1. Y=16, U=128, V=128, LANES=2, bypass=0, out_ready=1 -> out_valid exactly 3 cycles after accept; both lanes {0,0,0}.
2. Lane0 Y=235, lane1 Y=255, U=V=128 -> lane0 {254,254,254}, lane1 {255,255,255} (278 clamped); then Y=0 -> {0,0,0} (negative clamped).
3. Y=81, U=90, V=240 -> {254,0,0}: G pre-clamp sum -35300 floors to -1, B sum -67078 floors to -2.
4. Back-to-back beats with out_ready held 0 for 5 cycles mid-stream -> out_data stable, in_ready=0 while stalled, no beat lost or duplicated, order preserved.
5. FRAME_PIXELS=8, LANES=2, continuous stream -> out_last on every 4th beat; pix_count runs 2,4,6 then 0.
6. Bypass beat Y=(10,20), U=30, V=40 interleaved with normal beats -> {10,30,40} and {20,30,40}. A clr pulse while 2 beats are in flight -> out_valid=0 next cycle, pix_count=0; clr coinciding with in_valid -> that beat never emerges.
